// File: rtl/jtframe_autofire.sv
// Per-player turbo stage: held fire buttons with turbo enabled become a square
// wave counted in video frames; every other bit is registered straight through.
module jtframe_autofire_lane #(
  parameter int RATE = 3,
  parameter int CW   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic turbo,
  input  logic btn,
  output logic out_d
);
  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

  localparam logic [CW-1:0] LAST = CW'(RATE - 1);

  state_t          st_q, st_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    out_d = btn;
    case (st_q)
      IDLE: begin
        // a press coincident with a tick starts at cnt 0; that tick is not counted
        if (turbo && btn) begin
          st_d  = ON;
          cnt_d = '0;
        end
      end
      default: begin
        if (!btn) begin
          st_d  = IDLE;
          cnt_d = '0;
          out_d = 1'b0;
        end else if (!turbo) begin
          st_d  = IDLE;
          cnt_d = '0;
          out_d = btn;
        end else begin
          out_d = (st_q == ON);
          if (tick) begin
            if (cnt_q == LAST) begin
              st_d  = (st_q == ON) ? OFF : ON;
              cnt_d = '0;
              out_d = (st_q != ON);
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= IDLE;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

module jtframe_autofire #(
  parameter int BUTTONS = 2,
  parameter int RATE    = 3,
  parameter int CW      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               LVBL,
  input  logic [BUTTONS-1:0] turbo,
  input  logic [15:0]        joy_in,
  output logic [15:0]        joy_out
);
  logic               lvbl_l_q, lvbl_l_d;
  logic               tick;
  logic [BUTTONS-1:0] btn_d;
  logic [15:0]        joy_q, joy_d;

  assign lvbl_l_d = LVBL;
  assign tick     = lvbl_l_q & ~LVBL;

  for (genvar b = 0; b < BUTTONS; b++) begin : g_lane
    jtframe_autofire_lane #(.RATE(RATE), .CW(CW)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .turbo (turbo[b]),
      .btn   (joy_in[4+b]),
      .out_d (btn_d[b])
    );
  end

  always_comb begin
    joy_d              = joy_in;
    joy_d[4 +: BUTTONS] = btn_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lvbl_l_q <= 1'b1;
      joy_q    <= '0;
    end else begin
      lvbl_l_q <= lvbl_l_d;
      joy_q    <= joy_d;
    end
  end

  assign joy_out = joy_q;
endmodule

// File: tb/tb_jtframe_autofire.sv
// Scoreboard bench for jtframe_autofire: a frame-count model predicts every
// registered output word; a few spot checks pin down the key behaviours.
module tb_jtframe_autofire;
  localparam int BUTTONS = 2;
  localparam int RATE    = 3;
  localparam int CW      = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               LVBL = 1'b1;
  logic [BUTTONS-1:0] turbo = '0;
  logic [15:0]        joy_in = '0;
  logic [15:0]        joy_out;

  jtframe_autofire #(.BUTTONS(BUTTONS), .RATE(RATE), .CW(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .LVBL    (LVBL),
    .turbo   (turbo),
    .joy_in  (joy_in),
    .joy_out (joy_out)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [15:0] sb[$];

  // model: ticks seen since the press; phase = (ticks / RATE) parity
  logic m_lvbl = 1'b1;
  logic m_act[BUTTONS];
  int   m_tk[BUTTONS];

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_step();
    logic [15:0] e;
    logic t;
    t = m_lvbl & ~LVBL;
    if (rst) begin
      e = '0;
      m_lvbl = 1'b1;
      for (int b = 0; b < BUTTONS; b++) begin m_act[b] = 1'b0; m_tk[b] = 0; end
    end else begin
      m_lvbl = LVBL;
      e = joy_in;
      for (int b = 0; b < BUTTONS; b++) begin
        if (m_act[b]) begin
          if (!joy_in[4+b]) begin
            m_act[b] = 1'b0; e[4+b] = 1'b0;
          end else if (!turbo[b]) begin
            m_act[b] = 1'b0;
          end else begin
            if (t) m_tk[b]++;
            e[4+b] = ((m_tk[b] / RATE) % 2) == 0;
          end
        end else if (turbo[b] && joy_in[4+b]) begin
          m_act[b] = 1'b1; m_tk[b] = 0; e[4+b] = 1'b1;
        end
      end
    end
    sb.push_back(e);
  endtask

  task automatic cyc();
    logic [15:0] e;
    @(posedge clk);
    model_step();
    #1;
    if (sb.size() == 0) chk("sb_empty", joy_out, ~joy_out);
    else begin
      e = sb.pop_front();
      chk("joy_out", joy_out, e);
    end
  endtask

  // one frame: LVBL high 3 clks, low 2 clks (tick on first low clk)
  task automatic frames(input int n);
    repeat (n) begin
      LVBL = 1'b1; repeat (3) cyc();
      LVBL = 1'b0; repeat (2) cyc();
    end
  endtask

  initial begin
    for (int b = 0; b < BUTTONS; b++) begin m_act[b] = 1'b0; m_tk[b] = 0; end
    #1;
    repeat (2) cyc();
    chk("reset", joy_out, 16'h0000);
    rst = 1'b0;

    // passthrough
    joy_in = 16'h0035; cyc();
    chk("pass35", joy_out, 16'h0035);
    for (int i = 0; i < 16; i++) begin
      joy_in = joy_in ^ (16'h1 << i); cyc();
      chk("pass_tog", joy_out, joy_in);
    end

    // turbo wave on bit 4, bit 5 and directions plain
    joy_in = 16'h0000; cyc();
    turbo = 2'b01; joy_in = 16'h0013; cyc();
    chk("turbo_start", {15'b0, joy_out[4]}, 16'd1);
    frames(20);
    joy_in = 16'h0023; frames(2);
    joy_in = 16'h0000; frames(1);

    // release during OFF on a tick cycle, then re-press
    joy_in = 16'h0010; cyc();
    frames(3);
    chk("in_off", {15'b0, joy_out[4]}, 16'd0);
    LVBL = 1'b1; repeat (3) cyc();
    LVBL = 1'b0; joy_in = 16'h0000; cyc();
    chk("rel_tick", {15'b0, joy_out[4]}, 16'd0);
    cyc();
    joy_in = 16'h0010; cyc();
    chk("repress", {15'b0, joy_out[4]}, 16'd1);

    // turbo disable mid-OFF while held
    frames(3);
    chk("off2", {15'b0, joy_out[4]}, 16'd0);
    turbo = 2'b00; cyc();
    chk("tdis", {15'b0, joy_out[4]}, 16'd1);
    frames(3);
    chk("tdis_hold", {15'b0, joy_out[4]}, 16'd1);
    turbo = 2'b01; frames(4);

    // press of bit 5 coincident with a tick
    joy_in = 16'h0000; turbo = 2'b10; LVBL = 1'b1; repeat (2) cyc();
    LVBL = 1'b0; joy_in = 16'h0020; cyc();
    chk("coinc", {15'b0, joy_out[5]}, 16'd1);
    cyc();
    frames(2);
    chk("coinc_on", {15'b0, joy_out[5]}, 16'd1);
    frames(8);

    // reset mid-burst with LVBL low, both buttons turbo
    turbo = 2'b11; joy_in = 16'h0030; cyc(); frames(4);
    LVBL = 1'b0; rst = 1'b1; cyc();
    chk("rst_mid", joy_out, 16'h0000);
    rst = 1'b0; cyc();
    chk("rst_restart", joy_out, 16'h0030);
    frames(8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
